// File: rtl/ascii_add_ctrl.sv
// Two-digit ASCII adder: takes two ASCII decimal digits over a valid/ready
// channel and returns their sum as one or two ASCII digits on an output channel.
module ascii_add_ctrl #(
  parameter bit LEAD_ZERO = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] CHAR_IN,
  input  logic       CHAR_VALID,
  output logic       CHAR_READY,
  output logic [7:0] OUT_CHAR,
  output logic       OUT_VALID,
  input  logic       OUT_READY,
  output logic       ERR,
  output logic       BUSY
);

  // state   | meaning
  // S_A     | await operand A
  // S_B     | await operand B
  // S_SUM   | register A + B (one cycle)
  // S_TENS  | present tens digit
  // S_UNITS | present units digit
  typedef enum logic [2:0] {
    S_A     = 3'd0,
    S_B     = 3'd1,
    S_SUM   = 3'd2,
    S_TENS  = 3'd3,
    S_UNITS = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [4:0] sum_q, sum_d;
  logic       err_q, err_d;

  logic       is_digit;
  logic [7:0] char_off;
  logic [3:0] digit;
  logic       accept;
  logic [4:0] sum_ab;
  logic       tens_ab;
  logic       tens_q;
  logic [4:0] units_full;
  logic [3:0] units_q;

  assign is_digit   = (CHAR_IN >= 8'h30) && (CHAR_IN <= 8'h39);
  assign char_off   = CHAR_IN - 8'h30;
  assign digit      = char_off[3:0];
  assign accept     = CHAR_VALID && CHAR_READY;
  assign sum_ab     = {1'b0, a_q} + {1'b0, b_q};
  assign tens_ab    = (sum_ab >= 5'd10);
  assign tens_q     = (sum_q >= 5'd10);
  assign units_full = tens_q ? (sum_q - 5'd10) : sum_q;
  assign units_q    = units_full[3:0];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_A;
      a_q     <= 4'd0;
      b_q     <= 4'd0;
      sum_q   <= 5'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    err_d   = 1'b0;
    case (state_q)
      S_A: begin
        if (accept) begin
          if (is_digit) begin
            a_d     = digit;
            state_d = S_B;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_B: begin
        if (accept) begin
          if (is_digit) begin
            b_d     = digit;
            state_d = S_SUM;
          end else begin
            // a bad second operand throws away the whole pair
            err_d   = 1'b1;
            a_d     = 4'd0;
            state_d = S_A;
          end
        end
      end
      S_SUM: begin
        sum_d   = sum_ab;
        state_d = (LEAD_ZERO || tens_ab) ? S_TENS : S_UNITS;
      end
      S_TENS: begin
        if (OUT_READY) state_d = S_UNITS;
      end
      S_UNITS: begin
        if (OUT_READY) state_d = S_A;
      end
      default: state_d = S_A;
    endcase
  end

  // outputs decode from state only, so reset clears them without waiting for a clock
  always_comb begin
    CHAR_READY = 1'b0;
    OUT_VALID  = 1'b0;
    OUT_CHAR   = 8'h00;
    BUSY       = (state_q != S_A);
    ERR        = err_q;
    case (state_q)
      S_A, S_B: CHAR_READY = 1'b1;
      S_TENS: begin
        OUT_VALID = 1'b1;
        OUT_CHAR  = 8'h30 + {7'd0, tens_q};
      end
      S_UNITS: begin
        OUT_VALID = 1'b1;
        OUT_CHAR  = 8'h30 + {4'd0, units_q};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ascii_add_ctrl.sv
// Scoreboard bench for ascii_add_ctrl: instance 0 has LEAD_ZERO=1, instance 1 has LEAD_ZERO=0.
module tb_ascii_add_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] cin [2];
  logic       cv [2];
  logic       ordy [2];
  logic       ordy_fix [2];
  logic       rnd_bit [2];
  logic       rnd_rdy;
  logic       crdy [2];
  logic [7:0] ochar [2];
  logic       oval [2];
  logic       err [2];
  logic       busy [2];

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q0 [$];
  logic [7:0] exp_q1 [$];
  int exp_err [2];
  int err_seen [2];
  logic       have_a [2];
  logic [3:0] a_mdl [2];
  logic [7:0] hold_char [2];
  logic       hold_v [2];

  always #5 CLK = ~CLK;

  assign ordy[0] = rnd_rdy ? rnd_bit[0] : ordy_fix[0];
  assign ordy[1] = rnd_rdy ? rnd_bit[1] : ordy_fix[1];

  always @(posedge CLK) begin
    #1;
    rnd_bit[0] = ($urandom_range(0, 99) < 60);
    rnd_bit[1] = ($urandom_range(0, 99) < 60);
  end

  ascii_add_ctrl #(.LEAD_ZERO(1'b1)) u_lz1 (
    .CLK(CLK), .RST(RST), .CHAR_IN(cin[0]), .CHAR_VALID(cv[0]), .CHAR_READY(crdy[0]),
    .OUT_CHAR(ochar[0]), .OUT_VALID(oval[0]), .OUT_READY(ordy[0]), .ERR(err[0]), .BUSY(busy[0])
  );

  ascii_add_ctrl #(.LEAD_ZERO(1'b0)) u_lz0 (
    .CLK(CLK), .RST(RST), .CHAR_IN(cin[1]), .CHAR_VALID(cv[1]), .CHAR_READY(crdy[1]),
    .OUT_CHAR(ochar[1]), .OUT_VALID(oval[1]), .OUT_READY(ordy[1]), .ERR(err[1]), .BUSY(busy[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int i, input logic [7:0] c);
    if (i == 0) exp_q0.push_back(c);
    else exp_q1.push_back(c);
  endtask

  task automatic model_accept(input int i, input logic [7:0] c);
    int s;
    if (c >= 8'h30 && c <= 8'h39) begin
      if (!have_a[i]) begin
        a_mdl[i]  = c[3:0];
        have_a[i] = 1'b1;
      end else begin
        s = int'(a_mdl[i]) + int'(c[3:0]);
        have_a[i] = 1'b0;
        if (i == 0 || s >= 10) push_exp(i, 8'(48 + s / 10));
        push_exp(i, 8'(48 + s % 10));
      end
    end else begin
      exp_err[i]++;
      have_a[i] = 1'b0;
    end
  endtask

  task automatic mon(input int i);
    logic [7:0] e;
    logic       got_e;
    if (RST) begin
      hold_v[i] = 1'b0;
    end else begin
      if (oval[i]) begin
        if (hold_v[i]) chk($sformatf("hold%0d", i), ochar[i], hold_char[i]);
        if (ordy[i]) begin
          got_e = 1'b0;
          e = 8'h00;
          if (i == 0 && exp_q0.size() > 0) begin e = exp_q0.pop_front(); got_e = 1'b1; end
          if (i == 1 && exp_q1.size() > 0) begin e = exp_q1.pop_front(); got_e = 1'b1; end
          if (got_e) chk($sformatf("out%0d", i), ochar[i], e);
          else begin
            checks++;
            failures++;
            $display("FAIL unexpected_out%0d got=0x%0h exp=none", i, ochar[i]);
          end
          hold_v[i] = 1'b0;
        end else begin
          hold_v[i]    = 1'b1;
          hold_char[i] = ochar[i];
        end
      end else begin
        chk($sformatf("idle_char%0d", i), ochar[i], 8'h00);
        hold_v[i] = 1'b0;
      end
      if (err[i]) err_seen[i]++;
    end
  endtask

  always @(negedge CLK) begin
    for (int i = 0; i < 2; i++) mon(i);
  end

  // called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input int i, input logic [7:0] c, output int waited);
    bit done;
    done = 1'b0;
    waited = 0;
    cin[i] = c;
    cv[i]  = 1'b1;
    while (!done && waited < 300) begin
      @(negedge CLK);
      if (crdy[i]) begin
        model_accept(i, c);
        done = 1'b1;
      end else begin
        waited++;
      end
      @(posedge CLK);
      #1;
    end
    cv[i]  = 1'b0;
    cin[i] = 8'h00;
    if (!done) chk($sformatf("send_timeout%0d", i), 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int i);
    bit idle;
    int sz;
    idle = 1'b0;
    for (int n = 0; n < 600 && !idle; n++) begin
      @(negedge CLK);
      sz = (i == 0) ? exp_q0.size() : exp_q1.size();
      if (sz == 0 && crdy[i] && !busy[i]) idle = 1'b1;
      @(posedge CLK);
      #1;
    end
    if (!idle) chk($sformatf("idle_timeout%0d", i), 32'd0, 32'd1);
  endtask

  logic [7:0] bad_tbl [6];
  int w;
  logic [7:0] c;

  initial begin
    bad_tbl[0] = 8'h2F; bad_tbl[1] = 8'h3A; bad_tbl[2] = 8'h41;
    bad_tbl[3] = 8'h00; bad_tbl[4] = 8'h20; bad_tbl[5] = 8'hFF;
    RST = 1'b1;
    rnd_rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cin[i] = 8'h00; cv[i] = 1'b0; ordy_fix[i] = 1'b1;
      exp_err[i] = 0; err_seen[i] = 0; have_a[i] = 1'b0; a_mdl[i] = 4'd0;
      hold_v[i] = 1'b0; hold_char[i] = 8'h00;
    end
    #12;
    chk("rst_crdy", crdy[0], 1'b1);
    chk("rst_oval", oval[0], 1'b0);
    chk("rst_ochar", ochar[0], 8'h00);
    chk("rst_err", err[0], 1'b0);
    chk("rst_busy", busy[0], 1'b0);
    chk("rst_crdy_lz0", crdy[1], 1'b1);
    #11 RST = 1'b0;
    @(posedge CLK); #1;

    // '7' + '5' with sink always ready
    send(0, 8'h37, w);
    send(0, 8'h35, w);
    chk("sum_oval", oval[0], 1'b0);
    chk("sum_crdy", crdy[0], 1'b0);
    chk("sum_busy", busy[0], 1'b1);
    @(posedge CLK); #1;
    chk("tens_oval", oval[0], 1'b1);
    chk("tens_char", ochar[0], 8'h31);
    @(posedge CLK); #1;
    chk("units_char", ochar[0], 8'h32);
    @(posedge CLK); #1;
    chk("done_crdy", crdy[0], 1'b1);
    chk("done_busy", busy[0], 1'b0);

    // zero sums and leading-zero suppression
    send(0, 8'h30, w); send(0, 8'h30, w);
    wait_idle(0);
    send(1, 8'h30, w); send(1, 8'h30, w);
    @(posedge CLK); #1;
    chk("lz0_first_is_units", ochar[1], 8'h30);
    @(posedge CLK); #1;
    chk("lz0_back_to_a", crdy[1], 1'b1);
    send(1, 8'h34, w); send(1, 8'h33, w);
    wait_idle(1);
    send(1, 8'h39, w); send(1, 8'h35, w);
    wait_idle(1);

    // rejected operands, back-to-back errors
    send(0, 8'h41, w);
    chk("err_a_pulse", err[0], 1'b1);
    chk("err_a_stay", busy[0], 1'b0);
    send(0, 8'h42, w);
    chk("err_b2b_wait", w, 0);
    chk("err_b2b_pulse", err[0], 1'b1);
    @(posedge CLK); #1;
    chk("err_clear", err[0], 1'b0);
    send(0, 8'h33, w); send(0, 8'h2F, w);
    chk("err_b_pulse", err[0], 1'b1);
    chk("err_b_to_a", busy[0], 1'b0);
    send(0, 8'h39, w); send(0, 8'h39, w);
    wait_idle(0);

    // stalled sink, stray characters ignored while busy
    ordy_fix[0] = 1'b0;
    send(0, 8'h39, w); send(0, 8'h39, w);
    @(posedge CLK); #1;
    cin[0] = 8'h41; cv[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      chk("stall_oval", oval[0], 1'b1);
      chk("stall_char", ochar[0], 8'h31);
      chk("stall_crdy", crdy[0], 1'b0);
    end
    @(posedge CLK); #1;
    cv[0] = 1'b0; cin[0] = 8'h00; ordy_fix[0] = 1'b1;
    wait_idle(0);

    // reset in the middle of an output
    ordy_fix[0] = 1'b0;
    send(0, 8'h35, w); send(0, 8'h36, w);
    @(posedge CLK); #1;
    chk("pre_rst_oval", oval[0], 1'b1);
    #2 RST = 1'b1;
    #1;
    chk("async_rst_oval", oval[0], 1'b0);
    chk("async_rst_char", ochar[0], 8'h00);
    chk("async_rst_crdy", crdy[0], 1'b1);
    chk("async_rst_busy", busy[0], 1'b0);
    exp_q0.delete();
    have_a[0] = 1'b0;
    ordy_fix[0] = 1'b1;
    @(posedge CLK); #3 RST = 1'b0;
    send(0, 8'h32, w);
    chk("first_edge_accept", w, 0);
    send(0, 8'h32, w);
    wait_idle(0);

    // random streams with random sink readiness
    rnd_rdy = 1'b1;
    for (int k = 0; k < 250; k++) begin
      if ($urandom_range(0, 9) < 7) c = 8'(48 + $urandom_range(0, 9));
      else c = bad_tbl[$urandom_range(0, 5)];
      send(k % 2, c, w);
    end
    wait_idle(0);
    wait_idle(1);
    rnd_rdy = 1'b0;
    @(posedge CLK); #1;

    chk("err_count0", err_seen[0], exp_err[0]);
    chk("err_count1", err_seen[1], exp_err[1]);
    chk("queue_left0", exp_q0.size(), 0);
    chk("queue_left1", exp_q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
